// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard/forwarding controller.
//   - register-number width and the register-number type
//   - forwarding mux select encodings for the EX operand muxes
//   - mult/div sequencer state encoding and counter width
package hazard_pkg;

    localparam int REG_W = 5;
    localparam int CNT_W = 4;

    typedef logic [REG_W-1:0] reg_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard/forwarding controller.
//   master: datapath side, drives ID decode fields and the EX branch outcome,
//           receives the register enables/flushes and forwarding selects.
//   slave : controller side.
// Control semantics (single-cycle, no handshake): in any cycle a *_write of 0
// holds that register on the next rising edge, a *_flush of 1 loads a bubble
// on the next rising edge, and flush wins over write for the same register.
// md_state exposes the mult/div sequencer state for observation.
interface hazard_fwd_ctrl_if;
    import hazard_pkg::*;

    reg_t      id_rs;
    reg_t      id_rt;
    logic      id_use_rs;
    logic      id_use_rt;
    reg_t      id_dest;
    logic      id_regwrite;
    logic      id_memread;
    logic      id_muldiv;
    logic      ex_branch_taken;

    logic      pc_write;
    logic      ifid_write;
    logic      ifid_flush;
    logic      idex_write;
    logic      idex_flush;
    logic      exmem_flush;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic      md_busy;
    md_state_t md_state;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_dest,
               id_regwrite, id_memread, id_muldiv, ex_branch_taken,
        input  pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
               exmem_flush, fwd_a, fwd_b, md_busy, md_state
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_dest,
               id_regwrite, id_memread, id_muldiv, ex_branch_taken,
        output pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
               exmem_flush, fwd_a, fwd_b, md_busy, md_state
    );

endinterface

// File: rtl/hazard_fwd_ctrl_fwd_sel.sv
// Forwarding select for one EX operand.
//   src/use_src            : source register of the EX instruction and its read flag
//   mem_dest/mem_regwrite  : destination info of the instruction in MEM
//   wb_dest/wb_regwrite    : destination info of the instruction in WB
//   sel                    : FWD_MEM, FWD_WB or FWD_RF
// MEM is the younger producer so it takes precedence; $0 is never forwarded.
module fwd_sel
    import hazard_pkg::*;
(
    input  reg_t       src,
    input  logic       use_src,
    input  reg_t       mem_dest,
    input  logic       mem_regwrite,
    input  reg_t       wb_dest,
    input  logic       wb_regwrite,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_RF;
        if (use_src && mem_regwrite && (mem_dest != '0) && (mem_dest == src)) begin
            sel = FWD_MEM;
        end else if (use_src && wb_regwrite && (wb_dest != '0) && (wb_dest == src)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for a 5-stage MIPS pipeline.
//   clk, rst_n : core clock, asynchronous active-low reset
//   bus        : slave side of hazard_fwd_ctrl_if (ID decode in, enables/flushes,
//                forwarding selects, md_busy and sequencer state out)
// Keeps a shadow of the EX/MEM/WB destination info so only ID decode fields
// and the EX branch outcome are needed. Priority: branch flush, then mult/div
// stall, then load-use stall.
module hazard_fwd_ctrl
    import hazard_pkg::*;
#(
    parameter int MULDIV_CYCLES = 4
)(
    input  logic clk,
    input  logic rst_n,
    hazard_fwd_ctrl_if.slave bus
);

    // EX slot shadow
    reg_t ex_rs, ex_rt, ex_dest;
    logic ex_use_rs, ex_use_rt, ex_regwrite, ex_memread, ex_muldiv;
    // MEM / WB slot shadows
    reg_t mem_dest, wb_dest;
    logic mem_regwrite, wb_regwrite;

    md_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic            md_stall;
    logic            load_use;

    logic pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_flush, md_busy;

    // Mult/div sequencer: the RUN cycle in which the op first sits in EX is
    // itself a stall cycle, so the counter starts at MULDIV_CYCLES-2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        md_stall  = 1'b0;
        case (state)
            RUN: begin
                if (ex_muldiv && !bus.ex_branch_taken) begin
                    md_stall  = 1'b1;
                    state_nxt = MD_BUSY;
                    cnt_nxt   = CNT_W'(MULDIV_CYCLES - 2);
                end
            end
            MD_BUSY: begin
                if (cnt != '0) begin
                    md_stall = 1'b1;
                    cnt_nxt  = cnt - CNT_W'(1);
                end else begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    assign load_use = ex_memread && (ex_dest != '0) &&
                      ((bus.id_use_rs && (bus.id_rs == ex_dest)) ||
                       (bus.id_use_rt && (bus.id_rt == ex_dest)));

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_write  = 1'b1;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        md_busy     = 1'b0;
        if (bus.ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (md_stall) begin
            // ID/EX is held, so a pending load-use needs no bubble here
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_flush = 1'b1;
            md_busy     = 1'b1;
        end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rs <= '0; ex_rt <= '0; ex_dest <= '0;
            ex_use_rs <= 1'b0; ex_use_rt <= 1'b0; ex_regwrite <= 1'b0;
            ex_memread <= 1'b0; ex_muldiv <= 1'b0;
            mem_dest <= '0; mem_regwrite <= 1'b0;
            wb_dest  <= '0; wb_regwrite  <= 1'b0;
        end else begin
            if (idex_flush) begin
                ex_rs <= '0; ex_rt <= '0; ex_dest <= '0;
                ex_use_rs <= 1'b0; ex_use_rt <= 1'b0; ex_regwrite <= 1'b0;
                ex_memread <= 1'b0; ex_muldiv <= 1'b0;
            end else if (idex_write) begin
                ex_rs       <= bus.id_rs;
                ex_rt       <= bus.id_rt;
                ex_dest     <= bus.id_dest;
                ex_use_rs   <= bus.id_use_rs;
                ex_use_rt   <= bus.id_use_rt;
                ex_regwrite <= bus.id_regwrite;
                ex_memread  <= bus.id_memread;
                ex_muldiv   <= bus.id_muldiv;
            end
            if (exmem_flush) begin
                mem_dest     <= '0;
                mem_regwrite <= 1'b0;
            end else begin
                mem_dest     <= ex_dest;
                mem_regwrite <= ex_regwrite;
            end
            wb_dest     <= mem_dest;
            wb_regwrite <= mem_regwrite;
        end
    end

    fwd_sel u_fwd_a (
        .src          (ex_rs),
        .use_src      (ex_use_rs),
        .mem_dest     (mem_dest),
        .mem_regwrite (mem_regwrite),
        .wb_dest      (wb_dest),
        .wb_regwrite  (wb_regwrite),
        .sel          (bus.fwd_a)
    );

    fwd_sel u_fwd_b (
        .src          (ex_rt),
        .use_src      (ex_use_rt),
        .mem_dest     (mem_dest),
        .mem_regwrite (mem_regwrite),
        .wb_dest      (wb_dest),
        .wb_regwrite  (wb_regwrite),
        .sel          (bus.fwd_b)
    );

    assign bus.pc_write    = pc_write;
    assign bus.ifid_write  = ifid_write;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_write  = idex_write;
    assign bus.idex_flush  = idex_flush;
    assign bus.exmem_flush = exmem_flush;
    assign bus.md_busy     = md_busy;
    assign bus.md_state    = state;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl (MULDIV_CYCLES = 4).
// Control vector order: {pc_write, ifid_write, ifid_flush, idex_write,
//                        idex_flush, exmem_flush, md_busy}
module tb_hazard_fwd_ctrl;
    import hazard_pkg::*;

    localparam logic [6:0] C_RUN    = 7'b1101000;
    localparam logic [6:0] C_LDUSE  = 7'b0001100;
    localparam logic [6:0] C_BRANCH = 7'b1111100;
    localparam logic [6:0] C_MD     = 7'b0000011;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    hazard_fwd_ctrl_if bus ();

    hazard_fwd_ctrl #(.MULDIV_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // driver tasks
    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic [4:0] dest,
                          input logic rw, input logic mr, input logic md);
        bus.id_rs       = rs;
        bus.id_rt       = rt;
        bus.id_use_rs   = urs;
        bus.id_use_rt   = urt;
        bus.id_dest     = dest;
        bus.id_regwrite = rw;
        bus.id_memread  = mr;
        bus.id_muldiv   = md;
    endtask

    task automatic nop();
        set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // checkers
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_ctrl(input string tag, input logic [6:0] exp);
        #1;
        chk(tag, {1'b0, bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_write,
                  bus.idex_flush, bus.exmem_flush, bus.md_busy}, {1'b0, exp});
    endtask

    task automatic chk_fwd(input string tag, input logic [1:0] exp_a, input logic [1:0] exp_b);
        #1;
        chk(tag, {4'b0, bus.fwd_a, bus.fwd_b}, {4'b0, exp_a, exp_b});
    endtask

    task automatic drain();
        nop();
        repeat (3) tick();
    endtask

    initial begin
        bus.ex_branch_taken = 1'b0;
        nop();
        #2;
        chk_ctrl("reset_ctrl", C_RUN);
        chk_fwd("reset_fwd", 2'b00, 2'b00);
        chk("reset_state", {7'b0, bus.md_state}, {7'b0, RUN});
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drain();

        // add $3,$1,$2 ; sub $4,$3,$5
        set_id(5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0); tick();
        set_id(5'd3, 5'd5, 1, 1, 5'd4, 1, 0, 0);
        chk_ctrl("raw_adj_nostall", C_RUN);
        tick(); nop();
        chk_fwd("raw_adj_fwd_mem", 2'b10, 2'b00);
        drain();

        // add $3 ; or $7,$8,$9 ; sub $4,$3,$5
        set_id(5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0); tick();
        set_id(5'd8, 5'd9, 1, 1, 5'd7, 1, 0, 0); tick();
        set_id(5'd3, 5'd5, 1, 1, 5'd4, 1, 0, 0); tick(); nop();
        chk_fwd("raw_gap1_fwd_wb", 2'b01, 2'b00);
        drain();

        // add $3 ; two unrelated ; sub $4,$3,$5
        set_id(5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0); tick();
        set_id(5'd8, 5'd9, 1, 1, 5'd7, 1, 0, 0); tick();
        set_id(5'd8, 5'd9, 1, 1, 5'd7, 1, 0, 0); tick();
        set_id(5'd3, 5'd5, 1, 1, 5'd4, 1, 0, 0); tick(); nop();
        chk_fwd("raw_gap2_fwd_rf", 2'b00, 2'b00);
        drain();

        // lw $4,0($1) ; add $5,$4,$6  -> one stall cycle
        set_id(5'd1, 5'd4, 1, 0, 5'd4, 1, 1, 0); tick();
        set_id(5'd4, 5'd6, 1, 1, 5'd5, 1, 0, 0);
        chk_ctrl("lduse_stall", C_LDUSE);
        tick();
        chk_ctrl("lduse_one_cycle", C_RUN);
        tick(); nop();
        chk_fwd("lduse_fwd_wb", 2'b01, 2'b00);
        drain();

        // lw $4 ; unrelated ; add $5,$4,$6 -> no stall
        set_id(5'd1, 5'd4, 1, 0, 5'd4, 1, 1, 0); tick();
        set_id(5'd8, 5'd9, 1, 1, 5'd7, 1, 0, 0); tick();
        set_id(5'd4, 5'd6, 1, 1, 5'd5, 1, 0, 0);
        chk_ctrl("lduse_gap_nostall", C_RUN);
        tick(); nop();
        chk_fwd("lduse_gap_fwd_wb", 2'b01, 2'b00);
        drain();

        // addi $0,$1,5 ; add $2,$0,$0
        set_id(5'd1, 5'd0, 1, 0, 5'd0, 1, 0, 0); tick();
        set_id(5'd0, 5'd0, 1, 1, 5'd2, 1, 0, 0);
        chk_ctrl("r0_nostall", C_RUN);
        tick(); nop();
        chk_fwd("r0_no_fwd", 2'b00, 2'b00);
        drain();

        // lw $0 ; reader of $0
        set_id(5'd1, 5'd0, 1, 0, 5'd0, 1, 1, 0); tick();
        set_id(5'd0, 5'd0, 1, 1, 5'd2, 1, 0, 0);
        chk_ctrl("lw_r0_nostall", C_RUN);
        drain();

        // taken branch with a simultaneous load-use condition
        set_id(5'd1, 5'd4, 1, 0, 5'd4, 1, 1, 0); tick();
        set_id(5'd4, 5'd6, 1, 1, 5'd5, 1, 0, 0);
        bus.ex_branch_taken = 1'b1;
        chk_ctrl("branch_flush", C_BRANCH);
        tick();
        bus.ex_branch_taken = 1'b0;
        chk_ctrl("branch_one_cycle", C_RUN);
        drain();

        // mult (writes $8) ; add $9,$8,$3
        set_id(5'd1, 5'd2, 1, 1, 5'd8, 1, 0, 1); tick();
        set_id(5'd8, 5'd3, 1, 1, 5'd9, 1, 0, 0);
        chk_ctrl("md_stall1", C_MD);
        tick();
        chk_ctrl("md_stall2", C_MD);
        chk("md_state_busy", {7'b0, bus.md_state}, {7'b0, MD_BUSY});
        tick();
        chk_ctrl("md_stall3", C_MD);
        tick();
        chk_ctrl("md_release", C_RUN);
        tick(); nop();
        chk_fwd("md_dep_fwd_mem", 2'b10, 2'b00);
        drain();

        // reset asserted in MD_BUSY with cnt=1
        set_id(5'd1, 5'd2, 1, 1, 5'd8, 1, 0, 1); tick();
        nop();
        tick();
        tick();
        chk_ctrl("md_before_reset", C_MD);
        rst_n = 1'b0;
        chk_ctrl("md_async_reset_ctrl", C_RUN);
        chk_fwd("md_async_reset_fwd", 2'b00, 2'b00);
        chk("md_async_reset_state", {7'b0, bus.md_state}, {7'b0, RUN});
        #2;
        rst_n = 1'b1;
        tick();
        chk_ctrl("post_reset_run1", C_RUN);
        tick();
        chk_ctrl("post_reset_run2", C_RUN);
        tick();
        chk_ctrl("post_reset_run3", C_RUN);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
